conv_mac: RTL and testbench

CONV_MAC -- requirements
Module: conv_mac

---
 rtl/conv_mac.sv | 158 +++++++++++++++
 tb/tb_conv_mac.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac.sv
// conv_mac: K x K signed convolution MAC with a two-state weight loader
//   (LOAD_W / RUN) and a 3-stage product / row-sum / saturate pipeline.
// Latency: 3 edges from the accept edge to out_valid. Throughput: 1 window/cycle.
// Backpressure: every stage advances only when (!out_valid || out_ready);
//   in_ready follows that signal in RUN and is 0 while loading weights.
// Ports: clk, reset (async, active-high), clr (sync flush + reload), K (kernel
//   size), weight_in/weight_valid -> weights_loaded, window_in/window_valid ->
//   in_ready, out_data/out_valid <- out_ready.
module conv_mac #(
  parameter  int INW    = 16,
  parameter  int MAXK   = 3,
  parameter  int OUTW   = 32,
  localparam int K_SIZE = $clog2(MAXK + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clr,
  input  logic [K_SIZE-1:0]                    K,
  input  logic [INW-1:0]                       weight_in,
  input  logic                                 weight_valid,
  output logic                                 weights_loaded,
  input  logic [MAXK-1:0][MAXK-1:0][INW-1:0]   window_in,
  input  logic                                 window_valid,
  output logic                                 in_ready,
  output logic [OUTW-1:0]                      out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int PW   = 2 * INW;
  localparam int SUMW = PW + $clog2(MAXK * MAXK);
  // Saturation compare width: wide enough for both the raw sum and the limits.
  localparam int SATW = (SUMW > OUTW) ? SUMW : OUTW;
  localparam logic signed [SATW-1:0] SAT_MAX = {{(SATW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [SATW-1:0] SAT_MIN = {{(SATW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

  typedef enum logic {LOAD_W, RUN} state_t;

  state_t                               st_q, st_d;
  logic [K_SIZE-1:0]                    row_q, row_d, col_q, col_d;
  logic [MAXK-1:0][MAXK-1:0][INW-1:0]   w_q, w_d;

  logic [MAXK-1:0][MAXK-1:0][PW-1:0]    prod_q, prod_d;
  logic [MAXK-1:0][SUMW-1:0]            rsum_q, rsum_d;
  logic                                 v1_q, v2_q, ov_q;
  logic [OUTW-1:0]                      od_q, sat_d;

  logic signed [SUMW-1:0]               racc, total;
  logic signed [SATW-1:0]               tot_ext;
  logic                                 advance, accept;

  assign weights_loaded = (st_q == RUN);
  assign advance        = !ov_q || out_ready;
  assign in_ready       = (st_q == RUN) && advance;
  assign accept         = window_valid && in_ready;
  assign out_valid      = ov_q;
  assign out_data       = od_q;

  // Weight loader: (row, col) walks the K x K grid row-major, so a weight
  // store lands at W[idx/K][idx%K] without a divider.
  always_comb begin
    st_d  = st_q;
    row_d = row_q;
    col_d = col_q;
    w_d   = w_q;
    if (clr) begin
      st_d  = LOAD_W;
      row_d = '0;
      col_d = '0;
      w_d   = '0;
    end else if (st_q == LOAD_W && weight_valid) begin
      for (int r = 0; r < MAXK; r++) begin
        for (int c = 0; c < MAXK; c++) begin
          if (row_q == K_SIZE'(r) && col_q == K_SIZE'(c)) w_d[r][c] = weight_in;
        end
      end
      if (col_q == K - K_SIZE'(1)) begin
        col_d = '0;
        if (row_q == K - K_SIZE'(1)) begin
          row_d = '0;
          st_d  = RUN;
        end else begin
          row_d = row_q + K_SIZE'(1);
        end
      end else begin
        col_d = col_q + K_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= LOAD_W;
      row_q <= '0;
      col_q <= '0;
      w_q   <= '0;
    end else begin
      st_q  <= st_d;
      row_q <= row_d;
      col_q <= col_d;
      w_q   <= w_d;
    end
  end

  // Datapath: products, row sums, then the saturated total. Weights outside
  // the active K x K are zero, so no masking of the window is needed.
  always_comb begin
    prod_d  = '0;
    rsum_d  = '0;
    racc    = '0;
    total   = '0;
    tot_ext = '0;
    sat_d   = '0;
    for (int r = 0; r < MAXK; r++) begin
      for (int c = 0; c < MAXK; c++) begin
        prod_d[r][c] = PW'($signed(window_in[r][c])) * PW'($signed(w_q[r][c]));
      end
    end
    for (int r = 0; r < MAXK; r++) begin
      racc = '0;
      for (int c = 0; c < MAXK; c++) begin
        racc = racc + SUMW'($signed(prod_q[r][c]));
      end
      rsum_d[r] = racc;
    end
    for (int r = 0; r < MAXK; r++) begin
      total = total + $signed(rsum_q[r]);
    end
    tot_ext = SATW'(total);
    if (tot_ext > SAT_MAX)      sat_d = SAT_MAX[OUTW-1:0];
    else if (tot_ext < SAT_MIN) sat_d = SAT_MIN[OUTW-1:0];
    else                        sat_d = tot_ext[OUTW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      prod_q <= '0;
      rsum_q <= '0;
    end else if (clr) begin
      // Flush: data registers may keep stale values, only valids matter.
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (advance) begin
      v1_q   <= accept;
      prod_q <= prod_d;
      v2_q   <= v1_q;
      rsum_q <= rsum_d;
      ov_q   <= v2_q;
      od_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
module tb_conv_mac;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   clr = 1'b0;
  logic [1:0]             K = 2'd3;
  logic [15:0]            weight_in = '0;
  logic                   weight_valid = 1'b0;
  logic                   weights_loaded;
  logic [2:0][2:0][15:0]  window_in = '0;
  logic                   window_valid = 1'b0;
  logic                   in_ready;
  logic [31:0]            out_data;
  logic                   out_valid;
  logic                   out_ready = 1'b1;

  conv_mac #(.INW(16), .MAXK(3), .OUTW(32)) dut (
    .clk(clk), .reset(reset), .clr(clr), .K(K),
    .weight_in(weight_in), .weight_valid(weight_valid), .weights_loaded(weights_loaded),
    .window_in(window_in), .window_valid(window_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               k;
    logic [8:0][15:0] w;
    logic [8:0][15:0] win;
    longint           exp;
  } vec_t;

  vec_t   tv [6];
  int     mw [3][3];
  longint sb [$];
  longint next_exp = 0;
  int     n_cmp = 0, n_bad = 0, n_pop = 0;
  bit     bp_mode = 1'b0, stall_q = 1'b0;
  logic [31:0] hold_dat = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Independent reference: plain dot product over the loaded weights, clamped.
  function automatic longint model(input logic [2:0][2:0][15:0] w);
    longint s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += longint'(mw[r][c]) * longint'($signed(w[r][c]));
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    return s;
  endfunction

  // Scoreboard: push on accept, pop on transfer, watch stalls.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (stall_q && out_valid) chk("stall_hold", out_data, hold_dat);
      if (bp_mode && stall_q) chk("stall_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else chk("out_data", longint'($signed(out_data)), sb.pop_front());
        n_pop++;
      end
      if (window_valid && in_ready && !clr) sb.push_back(next_exp);
      stall_q  = out_valid && !out_ready;
      hold_dat = out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic set_win(input logic [8:0][15:0] v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        window_in[r][c] = v[r*3+c];
  endtask

  task automatic load(input int k, input logic [8:0][15:0] w);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mw[r][c] = 0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("in_ready_load", in_ready, 0);
    K = 2'(k);
    for (int i = 0; i < k*k; i++) begin
      weight_in    = w[i];
      weight_valid = 1'b1;
      mw[i/k][i%k] = int'($signed(w[i]));
      cyc();
      chk("weights_loaded", weights_loaded, (i == k*k-1) ? 1 : 0);
    end
    weight_valid = 1'b0;
  endtask

  task automatic send(input longint e);
    int n = 0;
    bit got = 1'b0;
    next_exp     = e;
    window_valid = 1'b1;
    while (!got && n < 50) begin
      #1;
      got = in_ready;
      cyc();
      n++;
    end
    window_valid = 1'b0;
    chk("accept", got, 1);
  endtask

  task automatic run_one(input longint e);
    int n = 1;
    send(e);
    while (!out_valid && n < 10) begin
      cyc();
      n++;
    end
    chk("latency", n, 3);
    cyc();
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ww [9] = '{1, -1, 2, -2, 3, -3, 4, -4, 5};
    int sent, base, i;
    bit acc;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Vector table
    for (int v = 0; v < 6; v++) begin
      tv[v].w = '0;
      tv[v].win = '0;
    end
    tv[0].k = 3; tv[0].exp = 45;
    for (int j = 0; j < 9; j++) begin tv[0].w[j] = 16'(j+1); tv[0].win[j] = 16'd1; end
    tv[1].k = 2; tv[1].exp = 76;
    for (int j = 0; j < 4; j++) tv[1].w[j] = 16'(j+1);
    for (int j = 0; j < 9; j++) tv[1].win[j] = 16'(10*(j/3) + j%3);
    tv[2].k = 3; tv[2].exp = SMAX;
    for (int j = 0; j < 9; j++) begin tv[2].w[j] = 16'h8000; tv[2].win[j] = 16'h8000; end
    tv[3].k = 3; tv[3].exp = SMIN;
    for (int j = 0; j < 9; j++) begin tv[3].w[j] = 16'h8000; tv[3].win[j] = 16'h7FFF; end
    tv[4].k = 1; tv[4].exp = -3;
    tv[4].w[0] = 16'hFFFD;
    for (int j = 0; j < 9; j++) tv[4].win[j] = 16'(10*(j/3) + j%3 + 1);
    tv[5].k = 3; tv[5].exp = 91;
    for (int j = 0; j < 9; j++) begin tv[5].w[j] = 16'(ww[j]); tv[5].win[j] = 16'(10*(j/3) + j%3 + 1); end

    // Reset state, before any clock edge
    #1 reset = 1'b1;
    window_valid = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_weights_loaded", weights_loaded, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    window_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Table-driven vectors; a stray weight in RUN must be ignored
    for (int v = 0; v < 6; v++) begin
      load(tv[v].k, tv[v].w);
      weight_in = 16'h1234; weight_valid = 1'b1;
      cyc();
      weight_valid = 1'b0;
      set_win(tv[v].win);
      run_one(tv[v].exp);
    end

    // Backpressure stream, out_ready pattern 1,0,0,1 (weights of tv[5])
    bp_mode = 1'b1;
    sent = 0;
    base = n_pop;
    i = 0;
    while ((sent < 5 || n_pop - base < 5) && i < 80) begin
      out_ready = pat[i % 4];
      if (sent < 5 && !window_valid) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            window_in[r][c] = 16'($urandom_range(0, 65535));
        next_exp     = model(window_in);
        window_valid = 1'b1;
      end
      #1;
      acc = window_valid && in_ready;
      cyc();
      if (acc) begin
        sent++;
        window_valid = 1'b0;
      end
      i++;
    end
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    chk("bp_delivered", n_pop - base, 5);
    chk("bp_sb_empty", sb.size(), 0);

    // clr with two results in flight and window_valid held high
    load(3, tv[0].w);
    set_win(tv[0].win);
    next_exp     = 45;
    window_valid = 1'b1;
    cyc(); cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    sb.delete();
    for (int j = 0; j < 5; j++) begin
      chk("clr_out_valid", out_valid, 0);
      chk("clr_weights_loaded", weights_loaded, 0);
      chk("clr_in_ready", in_ready, 0);
      cyc();
    end
    window_valid = 1'b0;
    load(3, tv[5].w);
    set_win(tv[5].win);
    run_one(91);

    // Asynchronous reset pulse between edges, mid-stream
    load(3, tv[0].w);
    set_win(tv[0].win);
    next_exp     = 45;
    window_valid = 1'b1;
    for (int j = 0; j < 10 && !out_valid; j++) cyc();
    chk("ar_pre_valid", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_weights_loaded", weights_loaded, 0);
    chk("ar_in_ready", in_ready, 0);
    #3 reset = 1'b0;
    sb.delete();
    window_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("ar_no_stale", out_valid, 0);
    end
    chk("ar_wl_after", weights_loaded, 0);
    load(3, tv[5].w);
    set_win(tv[5].win);
    run_one(91);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
